// File: rtl/hopfield_pkg.sv
// Shared types and arithmetic helpers for the Hopfield Hebbian trainer.
// Weights are bipolar-product accumulators with symmetric saturation.
package hopfield_pkg;

  localparam int DEF_NEURON_COUNT = 16;
  localparam int DEF_WEIGHT_WIDTH = 8;
  localparam int WMAX = 2 ** (DEF_WEIGHT_WIDTH - 1) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  function automatic int wmax(int ww);
    return (1 << (ww - 1)) - 1;
  endfunction

  function automatic int bipolar(logic a, logic b);
    return (a ~^ b) ? 1 : -1;
  endfunction

  // Clamp symmetrically so the most-negative code never appears.
  function automatic int sat_add(int w, int p, int lim);
    int s;
    s = w + p;
    if (s > lim) return lim;
    if (s < -lim) return -lim;
    return s;
  endfunction

endpackage

// File: rtl/hopfield_hebbian_trainer_if.sv
// Pattern handshake, control, status and weight read port of the trainer.
// master = pattern source / recall side, slave = trainer.
interface hopfield_hebbian_trainer_if #(
  parameter int NEURON_COUNT = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int MAX_PATTERNS = 4
) ();

  localparam int CW = $clog2(MAX_PATTERNS + 1);
  localparam int RW = $clog2(NEURON_COUNT);

  logic                             clear;
  logic                             pat_valid;
  logic [NEURON_COUNT-1:0]          pat_data;
  logic                             pat_ready;
  logic                             busy;
  logic                             full;
  logic [CW-1:0]                    pattern_count;
  logic                             weights_valid;
  // One spare bit so out-of-range rows can be addressed.
  logic [RW:0]                      w_rd_row;
  logic [NEURON_COUNT*WEIGHT_WIDTH-1:0] w_rd_data;

  modport master (
    output clear, pat_valid, pat_data, w_rd_row,
    input  pat_ready, busy, full, pattern_count,
    input  weights_valid, w_rd_data
  );

  modport slave (
    input  clear, pat_valid, pat_data, w_rd_row,
    output pat_ready, busy, full, pattern_count,
    output weights_valid, w_rd_data
  );

endinterface

// File: rtl/hopfield_row_update.sv
// Combinational Hebbian update of one weight row across all column lanes.
// Lane r (the diagonal) is always forced to zero.
module hopfield_row_update
  import hopfield_pkg::*;
#(
  parameter int NEURON_COUNT = DEF_NEURON_COUNT,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH
) (
  input  logic [NEURON_COUNT*WEIGHT_WIDTH-1:0] row_old,
  input  logic [NEURON_COUNT-1:0]              pattern,
  input  logic [$clog2(NEURON_COUNT)-1:0]      r,
  output logic [NEURON_COUNT*WEIGHT_WIDTH-1:0] row_new
);

  localparam int WW  = WEIGHT_WIDTH;
  localparam int LIM = wmax(WEIGHT_WIDTH);

  always_comb begin
    row_new = '0;
    for (int j = 0; j < NEURON_COUNT; j++) begin
      if (j != int'(r)) begin
        row_new[j*WW +: WW] = WW'(sat_add(
          int'($signed(row_old[j*WW +: WW])),
          bipolar(pattern[r], pattern[j]),
          LIM));
      end
    end
  end

endmodule

// File: rtl/hopfield_hebbian_trainer.sv
// Hebbian weight-matrix trainer: stores patterns one row per cycle and
// serves the matrix row by row to the recall logic.
module hopfield_hebbian_trainer
  import hopfield_pkg::*;
#(
  parameter int NEURON_COUNT = DEF_NEURON_COUNT,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int MAX_PATTERNS = 4
) (
  input logic clk,
  input logic rst,
  hopfield_hebbian_trainer_if.slave bus
);

  localparam int RW   = $clog2(NEURON_COUNT);
  localparam int CW   = $clog2(MAX_PATTERNS + 1);
  localparam int ROWW = NEURON_COUNT * WEIGHT_WIDTH;

  localparam logic [RW-1:0] LAST = RW'(NEURON_COUNT - 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_PATTERNS);

  state_t                  state;
  logic [RW-1:0]           r;
  logic [NEURON_COUNT-1:0] pat;
  logic [CW-1:0]           count;
  logic                    busy_q;
  logic                    ready_q;
  logic                    full_q;
  logic                    wv_q;
  logic [ROWW-1:0]         mat [NEURON_COUNT];
  logic [ROWW-1:0]         row_new;
  logic [CW-1:0]           count_inc;

  assign count_inc = count + 1'b1;

  hopfield_row_update #(
    .NEURON_COUNT(NEURON_COUNT),
    .WEIGHT_WIDTH(WEIGHT_WIDTH)
  ) u_row (
    .row_old(mat[r]),
    .pattern(pat),
    .r      (r),
    .row_new(row_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      r       <= '0;
      pat     <= '0;
      count   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      full_q  <= 1'b0;
      wv_q    <= 1'b0;
      for (int i = 0; i < NEURON_COUNT; i++)
        mat[i] <= '0;
    end else if (bus.clear) begin
      // Clear wins from any state and (re)starts at row 0.
      state   <= CLEAR;
      r       <= '0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
      wv_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.pat_valid && ready_q) begin
            pat     <= bus.pat_data;
            r       <= '0;
            state   <= TRAIN;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            wv_q    <= 1'b0;
          end
        end
        TRAIN: begin
          mat[r] <= row_new;
          r      <= r + 1'b1;
          if (r == LAST) begin
            state   <= IDLE;
            count   <= count_inc;
            busy_q  <= 1'b0;
            full_q  <= (count_inc == CMAX);
            ready_q <= (count_inc != CMAX);
            wv_q    <= 1'b1;
          end
        end
        CLEAR: begin
          mat[r] <= '0;
          r      <= r + 1'b1;
          if (r == LAST) begin
            state   <= IDLE;
            count   <= '0;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
            ready_q <= 1'b1;
            wv_q    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pat_ready     = ready_q;
  assign bus.busy          = busy_q;
  assign bus.full          = full_q;
  assign bus.pattern_count = count;
  assign bus.weights_valid = wv_q;

  assign bus.w_rd_data =
    (int'(bus.w_rd_row) < NEURON_COUNT) ?
    mat[bus.w_rd_row[RW-1:0]] : '0;

endmodule
